fb_draw: RTL and testbench

//  CHIP-8 64x32 monochrome framebuffer with sprite draw / clear engine. Upstream of

---
 rtl/fb_draw.sv | 162 ++++++++++++++++
 tb/tb_fb_draw.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_draw.sv
// fb_draw: CHIP-8 64x32 monochrome framebuffer with CLS/DRW sprite engine and a registered display read port.
// Build option: define FB_SPRITE_WRAP_EN to wrap sprites at the right/bottom edges instead of clipping them.
module fb_draw #(
  parameter int X_MAX  = 64,
  parameter int Y_MAX  = 32,
  parameter int ADDR_W = 12
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic                       cmd_clear_i,
  input  logic [7:0]                 cmd_x_i,
  input  logic [7:0]                 cmd_y_i,
  input  logic [3:0]                 cmd_n_i,
  input  logic [ADDR_W-1:0]          cmd_addr_i,
  output logic                       mem_req_o,
  output logic [ADDR_W-1:0]          mem_addr_o,
  input  logic                       mem_ack_i,
  input  logic [7:0]                 mem_data_i,
  output logic                       done_o,
  output logic                       collision_o,
  input  logic [$clog2(X_MAX)-1:0]   pix_x_i,
  input  logic [$clog2(Y_MAX)-1:0]   pix_y_i,
  input  logic                       pix_en_i,
  output logic                       pix_o
);
  // state   | meaning
  // S_IDLE  | waiting for a command, cmd_ready_o high
  // S_CLEAR | zeroing one frame row per cycle
  // S_FETCH | requesting sprite byte for current row, waiting for ack
  // S_WRITE | read-modify-write XOR of the sprite byte into the frame row
  // S_DONE  | one-cycle done pulse
  localparam int XW = $clog2(X_MAX);
  localparam int YW = $clog2(Y_MAX);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FETCH, S_WRITE, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [XW-1:0]       x0_q;
  logic [YW-1:0]       y0_q;
  logic [3:0]          n_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [YW-1:0]       row_q;
  logic [7:0]          byte_q;
  logic                acc_q;
  logic                coll_q;
  logic                pix_q;
  logic [X_MAX-1:0]    fb_q [Y_MAX];

  logic [7:0]          rev;
  logic [2*X_MAX-1:0]  span;
  logic [X_MAX-1:0]    mask;
  logic [X_MAX-1:0]    old_word;
  logic [YW:0]         y_sum;
  logic [YW-1:0]       wr_row;
  logic                row_ok;
  logic                hit;
  logic                last_row;
  logic                unused_bits;

  // Sprite bit 7 is the leftmost pixel, i.e. the lowest word index.
  always_comb begin
    rev = '0;
    for (int i = 0; i < 8; i++) rev[i] = byte_q[7-i];
    span   = {{(2*X_MAX-8){1'b0}}, rev} << x0_q;
    y_sum  = {1'b0, y0_q} + (YW+1)'(row_q);
    wr_row = y_sum[YW-1:0];
`ifdef FB_SPRITE_WRAP_EN
    mask   = span[X_MAX-1:0] | span[2*X_MAX-1:X_MAX];
    row_ok = 1'b1;
`else
    mask   = span[X_MAX-1:0];
    row_ok = ~y_sum[YW];
`endif
    old_word = fb_q[wr_row];
    hit      = row_ok & (|(old_word & mask));
    last_row = (row_q[3:0] == n_q - 4'd1);
  end

  assign unused_bits = ^{cmd_x_i[7:XW], cmd_y_i[7:YW], span, y_sum};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          if (cmd_clear_i)          state_d = S_CLEAR;
          else if (cmd_n_i == 4'd0) state_d = S_DONE;
          else                      state_d = S_FETCH;
        end
      end
      S_CLEAR: if (row_q == YW'(Y_MAX-1)) state_d = S_DONE;
      S_FETCH: if (mem_ack_i) state_d = S_WRITE;
      S_WRITE: state_d = last_row ? S_DONE : S_FETCH;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_o = (state_q == S_IDLE);
    mem_req_o   = (state_q == S_FETCH);
    mem_addr_o  = '0;
    if (state_q == S_FETCH) mem_addr_o = addr_q + ADDR_W'(row_q[3:0]);
    done_o      = (state_q == S_DONE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      x0_q   <= '0;
      y0_q   <= '0;
      n_q    <= '0;
      addr_q <= '0;
      row_q  <= '0;
      byte_q <= '0;
      acc_q  <= 1'b0;
      coll_q <= 1'b0;
      pix_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid_i) begin
            x0_q   <= cmd_x_i[XW-1:0];
            y0_q   <= cmd_y_i[YW-1:0];
            n_q    <= cmd_n_i;
            addr_q <= cmd_addr_i;
            row_q  <= '0;
            acc_q  <= 1'b0;
          end
        end
        S_CLEAR: row_q <= row_q + 1'b1;
        S_FETCH: if (mem_ack_i) byte_q <= mem_data_i;
        S_WRITE: begin
          acc_q <= acc_q | hit;
          row_q <= row_q + 1'b1;
        end
        default: ;
      endcase
      // Collision is published as DONE is entered so it is valid alongside done_o.
      if (state_d == S_DONE && state_q != S_DONE)
        coll_q <= (state_q == S_WRITE) ? (acc_q | hit) : 1'b0;
      pix_q <= fb_q[pix_y_i][pix_x_i] & pix_en_i;
    end
  end

  // Frame contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (state_q == S_CLEAR)
      fb_q[row_q] <= '0;
    else if (state_q == S_WRITE && row_ok)
      fb_q[wr_row] <= old_word ^ mask;
  end

  assign collision_o = coll_q;
  assign pix_o       = pix_q;
endmodule

// File: tb/tb_fb_draw.sv
// tb_fb_draw: scoreboard bench for fb_draw; a pixel-level frame model predicts display reads, collision and fetch addresses.
module tb_fb_draw;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cmd_valid_i, cmd_clear_i;
  logic [7:0]  cmd_x_i, cmd_y_i;
  logic [3:0]  cmd_n_i;
  logic [11:0] cmd_addr_i;
  logic        cmd_ready_o, mem_req_o, mem_ack_i, done_o, collision_o, pix_o;
  logic [11:0] mem_addr_o;
  logic [7:0]  mem_data_i;
  logic [5:0]  pix_x_i;
  logic [4:0]  pix_y_i;
  logic        pix_en_i;

  fb_draw dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_clear_i(cmd_clear_i),
    .cmd_x_i(cmd_x_i), .cmd_y_i(cmd_y_i), .cmd_n_i(cmd_n_i), .cmd_addr_i(cmd_addr_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
    .done_o(done_o), .collision_o(collision_o),
    .pix_x_i(pix_x_i), .pix_y_i(pix_y_i), .pix_en_i(pix_en_i), .pix_o(pix_o)
  );

  always #5 clk_i = ~clk_i;

  int          vectors = 0;
  int          miscompares = 0;
  logic [7:0]  smem [4096];
  logic [63:0] mfb [32];
  logic [11:0] addr_exp [$];
  bit          coll_exp [$];
  logic [11:0] pq [$];
  int          ack_delay = 0;
  int          ack_count = 0;
  int          req_cycles = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
    #1;
  endtask

  // Memory responder: acks after ack_delay waiting cycles, checks address and its stability.
  initial begin
    int          wcnt;
    bit          hold_v;
    logic [11:0] hold_addr;
    wcnt = 0; hold_v = 0; hold_addr = '0;
    mem_ack_i = 1'b0; mem_data_i = '0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        mem_ack_i = 1'b0; wcnt = 0; hold_v = 0;
      end else if (mem_ack_i) begin
        mem_ack_i = 1'b0; hold_v = 0;
      end else if (mem_req_o) begin
        req_cycles++;
        if (hold_v) chk("addr_hold", mem_addr_o, hold_addr);
        if (wcnt >= ack_delay) begin
          mem_ack_i  = 1'b1;
          mem_data_i = smem[mem_addr_o];
          ack_count++;
          wcnt = 0; hold_v = 0;
          if (addr_exp.size() == 0) chk("addr_extra", 32'(addr_exp.size()), 1);
          else chk("mem_addr", mem_addr_o, addr_exp.pop_front());
        end else begin
          wcnt++; hold_v = 1; hold_addr = mem_addr_o;
        end
      end
    end
  end

  task automatic model_draw(input logic [7:0] x, input logic [7:0] y, input int n,
                            input logic [11:0] addr, input int rows, output bit coll);
    int x0, y0, yy, xx;
    logic [7:0]  b;
    logic [11:0] a;
    coll = 0;
    x0 = int'(x) % 64;
    y0 = int'(y) % 32;
    for (int r = 0; r < n && r < rows; r++) begin
      a  = addr + 12'(r);
      b  = smem[a];
      yy = y0 + r;
`ifdef FB_SPRITE_WRAP_EN
      yy = yy % 32;
`else
      if (yy > 31) continue;
`endif
      for (int i = 0; i < 8; i++) begin
        if (!b[7-i]) continue;
        xx = x0 + i;
`ifdef FB_SPRITE_WRAP_EN
        xx = xx % 64;
`else
        if (xx > 63) continue;
`endif
        if (mfb[yy][xx]) coll = 1;
        mfb[yy][xx] = ~mfb[yy][xx];
      end
    end
  endtask

  task automatic run_cmd(input bit clr, input logic [7:0] x, input logic [7:0] y,
                         input logic [3:0] n, input logic [11:0] addr, input bit poke, output int lat);
    bit ec;
    int c;
    if (clr) begin
      for (int r = 0; r < 32; r++) mfb[r] = '0;
      ec = 0;
    end else begin
      for (int r = 0; r < int'(n); r++) addr_exp.push_back(addr + 12'(r));
      model_draw(x, y, int'(n), addr, 16, ec);
    end
    coll_exp.push_back(ec);
    tick();
    chk("ready_idle", cmd_ready_o, 1);
    cmd_valid_i = 1'b1; cmd_clear_i = clr; cmd_x_i = x; cmd_y_i = y; cmd_n_i = n; cmd_addr_i = addr;
    tick();
    if (poke) begin
      cmd_clear_i = 1'b1; cmd_n_i = 4'd0;
    end else cmd_valid_i = 1'b0;
    c = 1;
    while (!done_o && c < 3000) begin
      if (poke) chk("busy_ready", cmd_ready_o, 0);
      tick();
      c++;
    end
    cmd_valid_i = 1'b0;
    lat = c;
    if (!done_o) chk("done_timeout", done_o, 1);
    else chk("collision", collision_o, coll_exp.pop_front());
    tick();
    chk("done_pulse", done_o, 0);
    chk("coll_hold", collision_o, ec);
  endtask

  task automatic scan(input bit en, input int ylo, input int yhi);
    logic [11:0] e;
    for (int y = ylo; y <= yhi; y++) begin
      for (int x = 0; x < 64; x++) begin
        tick();
        if (pq.size() != 0) begin
          e = pq.pop_front();
          chk($sformatf("pix_%0d_%0d", e[11:7], e[6:1]), pix_o, e[0]);
        end
        pix_x_i = 6'(x); pix_y_i = 5'(y); pix_en_i = en;
        pq.push_back({5'(y), 6'(x), en & mfb[y][x]});
      end
    end
    tick();
    e = pq.pop_front();
    chk($sformatf("pix_%0d_%0d", e[11:7], e[6:1]), pix_o, e[0]);
    pix_en_i = 1'b0;
  endtask

  initial begin
    int lat, acks0, reqs0, w;
    bit dc;
    for (int i = 0; i < 4096; i++) smem[i] = 8'h00;
    smem[12'h100] = 8'hF0;
    smem[12'h200] = 8'hFF; smem[12'h201] = 8'hFF;
    smem[12'h300] = 8'hA5;
    smem[12'hFFF] = 8'h81; smem[12'h000] = 8'h3C; smem[12'h001] = 8'hFF;
    smem[12'h400] = 8'h11; smem[12'h401] = 8'h22; smem[12'h402] = 8'h44; smem[12'h403] = 8'h88;
    rst_i = 1'b1; cmd_valid_i = 0; cmd_clear_i = 0; cmd_x_i = 0; cmd_y_i = 0; cmd_n_i = 0;
    cmd_addr_i = 0; pix_x_i = 0; pix_y_i = 0; pix_en_i = 0;
    tick(); tick();
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_collision", collision_o, 0);
    chk("rst_pix", pix_o, 0);
    chk("rst_ready", cmd_ready_o, 1);
    rst_i = 1'b0;

    // CLS timing and blank frame
    run_cmd(1, 0, 0, 0, 0, 0, lat);
    chk("cls_lat", lat, 33);
    scan(1, 0, 31);

    // single-row draw, then repeat for collision
    run_cmd(0, 0, 0, 1, 12'h100, 0, lat);
    chk("drw_lat", lat, 3);
    scan(1, 0, 1);
    run_cmd(0, 0, 0, 1, 12'h100, 0, lat);
    scan(1, 0, 0);
    run_cmd(0, 0, 0, 1, 12'h100, 0, lat);

    // n==0: immediate done, no fetch, collision back to 0
    reqs0 = req_cycles;
    run_cmd(0, 8'd5, 8'd5, 4'd0, 12'h100, 0, lat);
    chk("n0_lat", lat, 1);
    chk("n0_no_req", req_cycles, reqs0);
    scan(0, 0, 0);

    // edge clipping / wrapping, then coordinates taken modulo the frame
    run_cmd(0, 8'd60, 8'd31, 4'd2, 12'h200, 0, lat);
    run_cmd(0, 8'd70, 8'd40, 4'd1, 12'h300, 0, lat);
    scan(1, 0, 31);

    // slow memory, address wrap, busy command ignored
    ack_delay = 5;
    run_cmd(0, 8'd10, 8'd5, 4'd3, 12'hFFF, 1, lat);
    chk("slow_lat", lat, 22);
    chk("addr_q_drained", addr_exp.size(), 0);
    ack_delay = 0;
    scan(1, 0, 31);

    // reset during the WRITE of row 1
    acks0 = ack_count;
    addr_exp.push_back(12'h400); addr_exp.push_back(12'h401);
    model_draw(8'd20, 8'd12, 4, 12'h400, 1, dc);
    tick();
    cmd_valid_i = 1; cmd_clear_i = 0; cmd_x_i = 8'd20; cmd_y_i = 8'd12; cmd_n_i = 4'd4; cmd_addr_i = 12'h400;
    tick();
    cmd_valid_i = 0;
    w = 0;
    while (ack_count < acks0 + 2 && w < 50) begin tick(); w++; end
    chk("rst_wait_acks", ack_count, acks0 + 2);
    tick();
    chk("in_write", mem_req_o, 0);
    rst_i = 1'b1;
    #1;
    chk("abort_req", mem_req_o, 0);
    chk("abort_ready", cmd_ready_o, 1);
    chk("abort_done", done_o, 0);
    tick();
    rst_i = 1'b0;
    addr_exp.delete();
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("no_done_after_rst", done_o, 0);
    end
    scan(1, 0, 31);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
